// File: rtl/fuzz_campaign_sched_pkg.sv
// Shared Wishbone bundle types, scheduler state encoding and port ownership type
// for the fuzz campaign scheduler.
package fuzz_campaign_sched_pkg;

    typedef struct packed {
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic        we;
        logic        stb;
        logic        cyc;
    } wb_req_t;

    typedef struct packed {
        logic [31:0] dat;
        logic        ack;
        logic        err;
    } wb_rsp_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRAIN,
        ST_GAP,
        ST_RUN,
        ST_RECORD,
        ST_RELEASE
    } sched_state_t;

    typedef enum logic {
        GRANT_HOST,
        GRANT_FUZZ
    } grant_t;

    localparam wb_rsp_t WB_RSP_IDLE = '0;

endpackage

// File: rtl/fuzz_campaign_sched_if.sv
// One Wishbone link: the master drives req and consumes rsp, the slave the reverse.
interface fuzz_campaign_sched_if;
    import fuzz_campaign_sched_pkg::*;

    wb_req_t req;
    wb_rsp_t rsp;

    modport master (output req, input rsp);
    modport slave  (input req, output rsp);

endinterface

// File: rtl/fuzz_campaign_sched_wb_owner_mux.sv
// Zero-latency ownership mux in front of the IP Wishbone port, plus the single
// error pulse that tells a pre-empted host its cycle was taken away.
module fuzz_campaign_sched_wb_owner_mux
    import fuzz_campaign_sched_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst,
    input  grant_t                      grant,
    input  logic                        force_takeover,
    fuzz_campaign_sched_if.slave        host,
    fuzz_campaign_sched_if.slave        fuzz,
    fuzz_campaign_sched_if.master       ip
);

    logic err_pending;

    // The err lands in the first cycle after takeover, when the fuzzer already owns the port.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_pending <= 1'b0;
        end else begin
            err_pending <= force_takeover;
        end
    end

    always_comb begin
        ip.req   = host.req;
        host.rsp = ip.rsp;
        fuzz.rsp = WB_RSP_IDLE;
        if (grant == GRANT_FUZZ) begin
            ip.req       = fuzz.req;
            fuzz.rsp     = ip.rsp;
            host.rsp     = WB_RSP_IDLE;
            host.rsp.err = err_pending;
        end
    end

endmodule

// File: rtl/fuzz_campaign_sched.sv
// Campaign sequencer: takes the IP port from the host, runs NUM_ITER fuzzer iterations
// with a watchdog, tallies crashes/hangs and hands the port back.
module fuzz_campaign_sched
    import fuzz_campaign_sched_pkg::*;
#(
    parameter int NUM_ITER        = 16,
    parameter int ITER_W          = 16,
    parameter int DRAIN_TIMEOUT   = 64,
    parameter int RUN_TIMEOUT     = 4096,
    parameter int READ_DATA_WIDTH = 32,
    parameter bit STOP_ON_FAIL    = 1'b0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        abort,
    output logic                        busy,
    output logic                        done,
    output logic                        fz_enable,
    output logic                        fz_rst_n,
    input  logic                        fz_ack,
    input  logic                        fz_crash,
    input  logic                        fz_hang,
    input  logic                        fz_ovf,
    input  logic [READ_DATA_WIDTH-1:0]  fz_ip_output,
    fuzz_campaign_sched_if.slave        h_bus,
    fuzz_campaign_sched_if.slave        f_bus,
    fuzz_campaign_sched_if.master       ip_bus,
    output logic [ITER_W-1:0]           iter_cnt,
    output logic [ITER_W-1:0]           fail_cnt,
    output logic [ITER_W-1:0]           hang_cnt,
    output logic [ITER_W-1:0]           first_fail,
    output logic                        fail_valid,
    output logic [READ_DATA_WIDTH-1:0]  last_output
);

    localparam int DRAIN_W = $clog2(DRAIN_TIMEOUT) + 1;
    localparam int RUN_W   = $clog2(RUN_TIMEOUT) + 1;
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_TIMEOUT - 1);
    localparam logic [RUN_W-1:0]   RUN_LAST   = RUN_W'(RUN_TIMEOUT - 1);
    localparam logic [ITER_W:0]    ITER_GOAL  = (ITER_W + 1)'(NUM_ITER);

    sched_state_t state, state_nxt;
    grant_t       grant;

    logic [DRAIN_W-1:0]         drain_cnt;
    logic [RUN_W-1:0]           run_cnt;
    logic                       crash_flag;
    logic                       hang_flag;
    logic [READ_DATA_WIDTH-1:0] captured;

    logic begin_campaign;
    logic grab_port;
    logic release_port;
    logic force_takeover;
    logic wd_kill;
    logic last_iter;

    function automatic logic [ITER_W-1:0] sat_inc(input logic [ITER_W-1:0] v);
        return (&v) ? v : v + ITER_W'(1);
    endfunction

    assign last_iter = ({1'b0, iter_cnt} + (ITER_W + 1)'(1)) == ITER_GOAL;
    assign busy      = (state != ST_IDLE);
    assign fz_rst_n  = ~(rst | wd_kill);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // fz_ack is tested before the watchdog so a late ack still counts as a clean finish.
    always_comb begin
        state_nxt      = state;
        fz_enable      = 1'b0;
        wd_kill        = 1'b0;
        begin_campaign = 1'b0;
        grab_port      = 1'b0;
        release_port   = 1'b0;
        force_takeover = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start && !abort) begin
                    begin_campaign = 1'b1;
                    state_nxt      = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!h_bus.req.cyc) begin
                    grab_port = 1'b1;
                    state_nxt = ST_GAP;
                end else if (drain_cnt == DRAIN_LAST) begin
                    grab_port      = 1'b1;
                    force_takeover = 1'b1;
                    state_nxt      = ST_GAP;
                end
            end
            ST_GAP: begin
                state_nxt = ST_RUN;
            end
            ST_RUN: begin
                fz_enable = 1'b1;
                if (fz_ack) begin
                    state_nxt = ST_RECORD;
                end else if (run_cnt == RUN_LAST) begin
                    wd_kill   = 1'b1;
                    state_nxt = ST_RECORD;
                end
            end
            ST_RECORD: begin
                if (last_iter || abort || (STOP_ON_FAIL && (crash_flag || hang_flag))) begin
                    state_nxt = ST_RELEASE;
                end else begin
                    state_nxt = ST_GAP;
                end
            end
            ST_RELEASE: begin
                if (!f_bus.req.cyc) begin
                    release_port = 1'b1;
                    state_nxt    = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            grant <= GRANT_HOST;
            done  <= 1'b0;
        end else begin
            done <= release_port;
            if (grab_port) begin
                grant <= GRANT_FUZZ;
            end else if (release_port) begin
                grant <= GRANT_HOST;
            end
        end
    end

    // Sticky flags accumulate over the whole iteration, including the ack cycle itself.
    always_ff @(posedge clk) begin
        if (rst) begin
            iter_cnt    <= '0;
            fail_cnt    <= '0;
            hang_cnt    <= '0;
            first_fail  <= '0;
            fail_valid  <= 1'b0;
            last_output <= '0;
            captured    <= '0;
            drain_cnt   <= '0;
            run_cnt     <= '0;
            crash_flag  <= 1'b0;
            hang_flag   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (begin_campaign) begin
                        iter_cnt   <= '0;
                        fail_cnt   <= '0;
                        hang_cnt   <= '0;
                        first_fail <= '0;
                        fail_valid <= 1'b0;
                        drain_cnt  <= '0;
                    end
                end
                ST_DRAIN: begin
                    if (!grab_port) begin
                        drain_cnt <= drain_cnt + DRAIN_W'(1);
                    end
                end
                ST_GAP: begin
                    crash_flag <= 1'b0;
                    hang_flag  <= 1'b0;
                    run_cnt    <= '0;
                end
                ST_RUN: begin
                    run_cnt    <= run_cnt + RUN_W'(1);
                    crash_flag <= crash_flag | fz_crash | fz_ovf;
                    hang_flag  <= hang_flag | fz_hang | wd_kill;
                    if (fz_ack) begin
                        captured <= fz_ip_output;
                    end
                end
                ST_RECORD: begin
                    iter_cnt    <= sat_inc(iter_cnt);
                    last_output <= captured;
                    if (crash_flag) begin
                        fail_cnt <= sat_inc(fail_cnt);
                    end
                    if (hang_flag) begin
                        hang_cnt <= sat_inc(hang_cnt);
                    end
                    if ((crash_flag || hang_flag) && !fail_valid) begin
                        first_fail <= iter_cnt;
                        fail_valid <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    fuzz_campaign_sched_wb_owner_mux u_owner_mux (
        .clk            (clk),
        .rst            (rst),
        .grant          (grant),
        .force_takeover (force_takeover),
        .host           (h_bus),
        .fuzz           (f_bus),
        .ip             (ip_bus)
    );

endmodule
